reg_file_ctl: RTL and testbench

Parametrised two-read/one-write general-purpose register file for the datapath, replacing the fixed 32x64 array. Writes are clocked and gated by the write enable. Register 0 can be hardwired to zero. A built-in clear engine zeroes the array one entry per cycle after reset or on request and signals busy/done to the control unit. Reads are combinational and feed the ALU operand muxes in the same cycle.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_clear_fsm.sv | 56 +++++
 rtl/reg_file_ctl.sv | 81 ++++++++
 tb/tb_reg_file_ctl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types, default sizes and address-width helper for the register file
package reg_file_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clear_state_e;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 32;

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// rtl/reg_file_clear_fsm.sv - clear engine: walks every entry once after reset or on request
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear_req,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_clr_en
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    clear_state_e  r_state;
    logic [AW-1:0] r_idx;

    // Reset restarts the sweep from entry 0 even if a clear is already running.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear_req) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign o_busy     = (r_state == ST_CLEAR);
    assign o_done     = o_busy && (r_idx == LAST_IDX);
    assign o_clr_en   = o_busy;
    assign o_clr_addr = r_idx;

endmodule

// File: rtl/reg_file_ctl.sv
// rtl/reg_file_ctl.sv - 2R/1W register file with clear engine; REG_FILE_BYPASS_EN enables write-to-read forwarding
module reg_file_ctl
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    READ_REG_A,
    input  logic [AW-1:0]    READ_REG_B,
    input  logic [AW-1:0]    WRITE_REG,
    input  logic [WIDTH-1:0] WRITE_DATA,
    input  logic             REG_WRITE_ENABLE,
    input  logic             CLEAR_REQ,
    output logic [WIDTH-1:0] DATA_OUT_A,
    output logic [WIDTH-1:0] DATA_OUT_B,
    output logic             CLEAR_BUSY,
    output logic             CLEAR_DONE
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic          w_busy;
    logic          w_done;
    logic [AW-1:0] w_clr_addr;
    logic          w_clr_en;
    logic          w_wr_legal;
    logic          w_zero_a;
    logic          w_zero_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    reg_file_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_clear_req (CLEAR_REQ),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_clr_addr  (w_clr_addr),
        .o_clr_en    (w_clr_en)
    );

    assign w_wr_legal = REG_WRITE_ENABLE && !w_busy
                        && !((ZERO_REG != 0) && (WRITE_REG == '0));

    always_ff @(posedge CLK) begin
        if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_legal) begin
            r_mem[WRITE_REG] <= WRITE_DATA;
        end
    end

    assign w_zero_a = (ZERO_REG != 0) && (READ_REG_A == '0);
    assign w_zero_b = (ZERO_REG != 0) && (READ_REG_B == '0);

`ifdef REG_FILE_BYPASS_EN
    assign w_rd_a = (w_wr_legal && (WRITE_REG == READ_REG_A)) ? WRITE_DATA : r_mem[READ_REG_A];
    assign w_rd_b = (w_wr_legal && (WRITE_REG == READ_REG_B)) ? WRITE_DATA : r_mem[READ_REG_B];
`else
    assign w_rd_a = r_mem[READ_REG_A];
    assign w_rd_b = r_mem[READ_REG_B];
`endif

    // Busy masking keeps half-cleared contents off the ALU operand buses.
    always_comb begin
        DATA_OUT_A = '0;
        DATA_OUT_B = '0;
        if (!w_busy && !w_zero_a) DATA_OUT_A = w_rd_a;
        if (!w_busy && !w_zero_b) DATA_OUT_B = w_rd_b;
    end

    assign CLEAR_BUSY = w_busy;
    assign CLEAR_DONE = w_done;

endmodule

// File: tb/tb_reg_file_ctl.sv
// tb/tb_reg_file_ctl.sv - scoreboard bench for reg_file_ctl with directed and random stimulus
module tb_reg_file_ctl;
    localparam int W = 64;
    localparam int D = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [4:0]   ra = '0, rb = '0, wa = '0;
    logic [W-1:0] wd = '0;
    logic         we = 1'b0, clr = 1'b0;
    logic [W-1:0] da_z, db_z, da_n, db_n;
    logic         busy_z, done_z, busy_n, done_n;

    typedef struct {
        logic [W-1:0] a_z, b_z, a_n, b_n;
        logic         busy, done;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_z [D];
    logic [W-1:0] m_n [D];
    int           left = 0;
    int           tests = 0;
    int           fails = 0;

    always #5 CLK = ~CLK;

    reg_file_ctl #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) u_dut (
        .CLK(CLK), .RST(RST), .READ_REG_A(ra), .READ_REG_B(rb), .WRITE_REG(wa),
        .WRITE_DATA(wd), .REG_WRITE_ENABLE(we), .CLEAR_REQ(clr),
        .DATA_OUT_A(da_z), .DATA_OUT_B(db_z), .CLEAR_BUSY(busy_z), .CLEAR_DONE(done_z)
    );

    reg_file_ctl #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) u_dut_nz (
        .CLK(CLK), .RST(RST), .READ_REG_A(ra), .READ_REG_B(rb), .WRITE_REG(wa),
        .WRITE_DATA(wd), .REG_WRITE_ENABLE(we), .CLEAR_REQ(clr),
        .DATA_OUT_A(da_n), .DATA_OUT_B(db_n), .CLEAR_BUSY(busy_n), .CLEAR_DONE(done_n)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rd(input logic [4:0] a, input bit zreg, input bit bsy);
        logic [W-1:0] v;
        bit legal;
        if (bsy) return '0;
        if (zreg && a == 0) return '0;
        v = zreg ? m_z[a] : m_n[a];
        legal = we && !(zreg && wa == 0);
`ifdef REG_FILE_BYPASS_EN
        if (legal && wa == a) v = wd;
`endif
        return v;
    endfunction

    task automatic wipe();
        for (int i = 0; i < D; i++) begin
            m_z[i] = '0;
            m_n[i] = '0;
        end
        left = D;
    endtask

    task automatic cycle(input bit r, input bit c, input bit w, input logic [4:0] a_w,
                         input logic [W-1:0] d_w, input logic [4:0] a_a, input logic [4:0] a_b);
        exp_t e;
        bit   bsy;
        RST = r; clr = c; we = w; wa = a_w; wd = d_w; ra = a_a; rb = a_b;
        bsy    = (left > 0);
        e.busy = bsy;
        e.done = (left == 1);
        e.a_z  = rd(a_a, 1'b1, bsy);
        e.b_z  = rd(a_b, 1'b1, bsy);
        e.a_n  = rd(a_a, 1'b0, bsy);
        e.b_n  = rd(a_b, 1'b0, bsy);
        sb.push_back(e);
        @(posedge CLK);
        if (r) begin
            wipe();
        end else if (bsy) begin
            left--;
        end else if (c) begin
            wipe();
        end else if (w) begin
            if (a_w != 0) m_z[a_w] = d_w;
            m_n[a_w] = d_w;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] a_a, input logic [4:0] a_b);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, a_a, a_b);
    endtask

    task automatic read_all();
        for (int i = 0; i < D; i++) idle(1, 5'(i), 5'(D - 1 - i));
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("busy",   {63'b0, busy_z}, {63'b0, e.busy});
            chk("done",   {63'b0, done_z}, {63'b0, e.done});
            chk("busy_nz", {63'b0, busy_n}, {63'b0, e.busy});
            chk("done_nz", {63'b0, done_n}, {63'b0, e.done});
            chk("out_a",  da_z, e.a_z);
            chk("out_b",  db_z, e.b_z);
            chk("out_a_nz", da_n, e.a_n);
            chk("out_b_nz", db_n, e.b_n);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;
        RST = 1'b1;
        @(posedge CLK);
        wipe();
        #1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_z) busy_cnt++;
            idle(1, 5'(i), 5'(i + 3));
        end
        chk("reset_busy_len", 64'(busy_cnt), 64'(D));
        read_all();

        cycle(0, 0, 1, 5'd3, 64'hFFFF, 5'd0, 5'd0);
        cycle(0, 0, 1, 5'd1, 64'h5, 5'd3, 5'd1);
        idle(1, 5'd3, 5'd1);
        cycle(0, 0, 1, 5'd0, 64'h1234, 5'd0, 5'd0);
        idle(1, 5'd0, 5'd0);
        cycle(0, 0, 1, 5'd7, 64'hABCD, 5'd7, 5'd7);
        cycle(0, 0, 1, 5'd7, 64'hABCD, 5'd7, 5'd3);
        idle(1, 5'd7, 5'd1);

        for (int i = 1; i < D; i++) cycle(0, 0, 1, 5'(i), 64'(i), 5'(i), 5'(i - 1));
        read_all();
        cycle(0, 1, 1, 5'd9, 64'h99, 5'd9, 5'd2);
        for (int i = 0; i < D + 2; i++)
            cycle(0, 0, 1, 5'(i), 64'hDEAD_0000 + 64'(i), 5'(i), 5'd4);
        read_all();

        for (int i = 1; i < D; i++) cycle(0, 0, 1, 5'(i), 64'(i * 3), 5'd0, 5'd0);
        cycle(0, 1, 0, '0, '0, 5'd1, 5'd2);
        idle(10, 5'd1, 5'd2);
        cycle(1, 0, 1, 5'd5, 64'h55, 5'd5, 5'd5);
        idle(D + 3, 5'd5, 5'd6);
        cycle(1, 1, 0, '0, '0, 5'd0, 5'd1);
        idle(D + 1, 5'd1, 5'd2);

        for (int i = 0; i < 1500; i++) begin
            bit r, c, w;
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 99) == 0);
            w = ($urandom_range(0, 3) != 0);
            cycle(r, c, w, 5'($urandom), {$urandom, $urandom}, 5'($urandom), 5'($urandom));
        end
        idle(D + 1, 5'd0, 5'd0);
        read_all();

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge CLK);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
